// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: command codes, operand
// addresses and the frame-parser state encoding.
package uart_cmd_decoder_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_ADDR  = 4'd1,
      ST_WR_DATA  = 4'd2,
      ST_RD_ADDR  = 4'd3,
      ST_RD_WAIT  = 4'd4,
      ST_OP_A     = 4'd5,
      ST_OP_B     = 4'd6,
      ST_ALU_FUN  = 4'd7,
      ST_ALU_WAIT = 4'd8,
      ST_RSP_LO   = 4'd9,
      ST_RSP_HI   = 4'd10,
      ST_RSP_RD   = 4'd11
   } state_t;

   // States that consume frame bytes; every other state discards incoming bytes.
   function automatic logic is_frame_state(input state_t s);
      return (s == ST_IDLE)    || (s == ST_WR_ADDR) || (s == ST_WR_DATA) ||
             (s == ST_RD_ADDR) || (s == ST_OP_A)    || (s == ST_OP_B)    ||
             (s == ST_ALU_FUN);
   endfunction

endpackage

// File: rtl/uart_cmd_rsp_mux.sv
// Serialises a latched 1- or 2-byte result onto the response valid/ready
// handshake, low byte first.
module uart_cmd_rsp_mux #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_load,
   input  logic                    i_two,
   input  logic [2*DATA_WIDTH-1:0] i_data,
   input  logic                    i_ready,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic                    o_vld
);

   logic                  r_vld;
   logic                  r_hi_pend;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_hi;

   logic                  w_vld;
   logic                  w_hi_pend;
   logic [DATA_WIDTH-1:0] w_data;
   logic [DATA_WIDTH-1:0] w_hi;

   always_comb begin
      w_vld     = r_vld;
      w_hi_pend = r_hi_pend;
      w_data    = r_data;
      w_hi      = r_hi;
      if (i_load) begin
         w_vld     = 1'b1;
         w_data    = i_data[DATA_WIDTH-1:0];
         w_hi      = i_data[2*DATA_WIDTH-1:DATA_WIDTH];
         w_hi_pend = i_two;
      end else if (r_vld && i_ready) begin
         if (r_hi_pend) begin
            w_data    = r_hi;
            w_hi_pend = 1'b0;
         end else begin
            w_vld = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_vld     <= 1'b0;
         r_hi_pend <= 1'b0;
         r_data    <= '0;
         r_hi      <= '0;
      end else begin
         r_vld     <= w_vld;
         r_hi_pend <= w_hi_pend;
         r_data    <= w_data;
         r_hi      <= w_hi;
      end
   end

   assign o_vld  = r_vld;
   assign o_data = r_data;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses command frames from the UART receive path and dispatches register-file
// and ALU operations; results return through uart_cmd_rsp_mux.
//
// state    | meaning
// IDLE     | waiting for a command byte
// WR_ADDR  | RF write: expecting address      WR_DATA  | RF write: expecting data
// RD_ADDR  | RF read: expecting address       RD_WAIT  | waiting for rf_rd_vld
// OP_A     | expecting operand A              OP_B     | expecting operand B
// ALU_FUN  | expecting ALU function code      ALU_WAIT | waiting for alu_out_vld
// RSP_LO   | sending ALU result low byte      RSP_HI   | sending ALU result high byte
// RSP_RD   | sending RF read byte
module uart_cmd_decoder
   import uart_cmd_decoder_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int FUN_WIDTH    = 4,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [DATA_WIDTH-1:0]   i_rx_data,
   input  logic                    i_rx_vld,
   input  logic                    i_rx_err,
   output logic [ADDR_WIDTH-1:0]   o_rf_addr,
   output logic [DATA_WIDTH-1:0]   o_rf_wr_data,
   output logic                    o_rf_wr_en,
   output logic                    o_rf_rd_en,
   input  logic [DATA_WIDTH-1:0]   i_rf_rd_data,
   input  logic                    i_rf_rd_vld,
   output logic [FUN_WIDTH-1:0]    o_alu_fun,
   output logic                    o_alu_en,
   output logic                    o_alu_clk_en,
   input  logic [2*DATA_WIDTH-1:0] i_alu_out,
   input  logic                    i_alu_out_vld,
   output logic [DATA_WIDTH-1:0]   o_rsp_data,
   output logic                    o_rsp_vld,
   input  logic                    i_rsp_ready,
   output logic                    o_drop
);

   localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [ADDR_WIDTH-1:0]   r_rf_addr;
   logic [DATA_WIDTH-1:0]   r_rf_wr_data;
   logic                    r_rf_wr_en;
   logic                    r_rf_rd_en;
   logic [FUN_WIDTH-1:0]    r_alu_fun;
   logic                    r_alu_en;
   logic                    r_alu_clk_en;
   logic                    r_drop;
   logic [2*DATA_WIDTH-1:0] r_result;
   logic                    r_rsp_load;
   logic                    r_rsp_two;

   state_t                  w_state;
   logic [CNT_W-1:0]        w_cnt;
   logic [CNT_W-1:0]        w_cnt_inc;
   logic                    w_expired;
   logic [ADDR_WIDTH-1:0]   w_rf_addr;
   logic [DATA_WIDTH-1:0]   w_rf_wr_data;
   logic                    w_rf_wr_en;
   logic                    w_rf_rd_en;
   logic [FUN_WIDTH-1:0]    w_alu_fun;
   logic                    w_alu_en;
   logic                    w_alu_clk_en;
   logic                    w_drop;
   logic [2*DATA_WIDTH-1:0] w_result;
   logic                    w_rsp_load;
   logic                    w_rsp_two;
   logic                    w_rsp_hs;
   logic [DATA_WIDTH-1:0]   w_rsp_data;
   logic                    w_rsp_vld;

   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_rf_addr    = r_rf_addr;
      w_rf_wr_data = r_rf_wr_data;
      w_rf_wr_en   = 1'b0;
      w_rf_rd_en   = 1'b0;
      w_alu_fun    = r_alu_fun;
      w_alu_en     = 1'b0;
      w_alu_clk_en = r_alu_clk_en;
      w_drop       = 1'b0;
      w_result     = r_result;
      w_rsp_load   = 1'b0;
      w_rsp_two    = r_rsp_two;
      w_cnt_inc    = r_cnt + 1'b1;
      w_expired    = (w_cnt_inc == CNT_W'(WAIT_TIMEOUT));
      w_rsp_hs     = w_rsp_vld & i_rsp_ready;

      case (r_state)
         ST_RD_WAIT: begin
            w_cnt = w_cnt_inc;
            if (i_rf_rd_vld) begin
               w_result   = {{DATA_WIDTH{1'b0}}, i_rf_rd_data};
               w_rsp_load = 1'b1;
               w_rsp_two  = 1'b0;
               w_state    = ST_RSP_RD;
            end else if (w_expired) begin
               w_drop  = 1'b1;
               w_state = ST_IDLE;
            end
         end
         ST_ALU_WAIT: begin
            w_cnt = w_cnt_inc;
            if (i_alu_out_vld) begin
               w_result     = i_alu_out;
               w_rsp_load   = 1'b1;
               w_rsp_two    = 1'b1;
               w_alu_clk_en = 1'b0;
               w_state      = ST_RSP_LO;
            end else if (w_expired) begin
               w_drop       = 1'b1;
               w_alu_clk_en = 1'b0;
               w_state      = ST_IDLE;
            end
         end
         ST_RSP_RD: if (w_rsp_hs) w_state = ST_IDLE;
         ST_RSP_LO: if (w_rsp_hs) w_state = ST_RSP_HI;
         ST_RSP_HI: if (w_rsp_hs) w_state = ST_IDLE;
         default: begin
            if (i_rx_vld && i_rx_err) begin
               w_drop       = 1'b1;
               w_alu_clk_en = 1'b0;
               w_state      = ST_IDLE;
            end else if (i_rx_vld) begin
               case (r_state)
                  ST_IDLE: begin
                     if (i_rx_data == DATA_WIDTH'(CMD_RF_WR)) begin
                        w_state = ST_WR_ADDR;
                     end else if (i_rx_data == DATA_WIDTH'(CMD_RF_RD)) begin
                        w_state = ST_RD_ADDR;
                     end else if (i_rx_data == DATA_WIDTH'(CMD_ALU_OP)) begin
                        w_state      = ST_OP_A;
                        w_alu_clk_en = 1'b1;
                     end else if (i_rx_data == DATA_WIDTH'(CMD_ALU_NOP)) begin
                        w_state      = ST_ALU_FUN;
                        w_alu_clk_en = 1'b1;
                     end else begin
                        w_drop = 1'b1;
                     end
                  end
                  ST_WR_ADDR: begin
                     w_rf_addr = i_rx_data[ADDR_WIDTH-1:0];
                     w_state   = ST_WR_DATA;
                  end
                  ST_WR_DATA: begin
                     w_rf_wr_data = i_rx_data;
                     w_rf_wr_en   = 1'b1;
                     w_state      = ST_IDLE;
                  end
                  ST_RD_ADDR: begin
                     w_rf_addr  = i_rx_data[ADDR_WIDTH-1:0];
                     w_rf_rd_en = 1'b1;
                     w_cnt      = '0;
                     w_state    = ST_RD_WAIT;
                  end
                  ST_OP_A: begin
                     w_rf_addr    = ADDR_WIDTH'(OPA_ADDR);
                     w_rf_wr_data = i_rx_data;
                     w_rf_wr_en   = 1'b1;
                     w_state      = ST_OP_B;
                  end
                  ST_OP_B: begin
                     w_rf_addr    = ADDR_WIDTH'(OPB_ADDR);
                     w_rf_wr_data = i_rx_data;
                     w_rf_wr_en   = 1'b1;
                     w_state      = ST_ALU_FUN;
                  end
                  ST_ALU_FUN: begin
                     w_alu_fun = i_rx_data[FUN_WIDTH-1:0];
                     w_alu_en  = 1'b1;
                     w_cnt     = '0;
                     w_state   = ST_ALU_WAIT;
                  end
                  default: w_state = ST_IDLE;
               endcase
            end
         end
      endcase

      // Waiting and responding states never consume bytes.
      if (i_rx_vld && !is_frame_state(r_state)) w_drop = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_rf_addr    <= '0;
         r_rf_wr_data <= '0;
         r_rf_wr_en   <= 1'b0;
         r_rf_rd_en   <= 1'b0;
         r_alu_fun    <= '0;
         r_alu_en     <= 1'b0;
         r_alu_clk_en <= 1'b0;
         r_drop       <= 1'b0;
         r_result     <= '0;
         r_rsp_load   <= 1'b0;
         r_rsp_two    <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_cnt        <= w_cnt;
         r_rf_addr    <= w_rf_addr;
         r_rf_wr_data <= w_rf_wr_data;
         r_rf_wr_en   <= w_rf_wr_en;
         r_rf_rd_en   <= w_rf_rd_en;
         r_alu_fun    <= w_alu_fun;
         r_alu_en     <= w_alu_en;
         r_alu_clk_en <= w_alu_clk_en;
         r_drop       <= w_drop;
         r_result     <= w_result;
         r_rsp_load   <= w_rsp_load;
         r_rsp_two    <= w_rsp_two;
      end
   end

   uart_cmd_rsp_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_mux (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (r_rsp_load),
      .i_two   (r_rsp_two),
      .i_data  (r_result),
      .i_ready (i_rsp_ready),
      .o_data  (w_rsp_data),
      .o_vld   (w_rsp_vld)
   );

   assign o_rf_addr    = r_rf_addr;
   assign o_rf_wr_data = r_rf_wr_data;
   assign o_rf_wr_en   = r_rf_wr_en;
   assign o_rf_rd_en   = r_rf_rd_en;
   assign o_alu_fun    = r_alu_fun;
   assign o_alu_en     = r_alu_en;
   assign o_alu_clk_en = r_alu_clk_en;
   assign o_drop       = r_drop;
   assign o_rsp_data   = w_rsp_data;
   assign o_rsp_vld    = w_rsp_vld;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: frame-level stimulus pushes expected
// events into queues, a negedge monitor pops and compares them.
module tb_uart_cmd_decoder;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int FW = 4;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_vld = 1'b0;
   logic          rx_err = 1'b0;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wr_data;
   logic          rf_wr_en;
   logic          rf_rd_en;
   logic [DW-1:0] rf_rd_data = '0;
   logic          rf_rd_vld = 1'b0;
   logic [FW-1:0] alu_fun;
   logic          alu_en;
   logic          alu_clk_en;
   logic [2*DW-1:0] alu_out = '0;
   logic          alu_out_vld = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          rsp_vld;
   logic          rsp_ready = 1'b0;
   logic          drop;

   uart_cmd_decoder #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FUN_WIDTH (FW), .WAIT_TIMEOUT (TO)
   ) dut (
      .i_clk (clk), .i_reset (reset_n),
      .i_rx_data (rx_data), .i_rx_vld (rx_vld), .i_rx_err (rx_err),
      .o_rf_addr (rf_addr), .o_rf_wr_data (rf_wr_data),
      .o_rf_wr_en (rf_wr_en), .o_rf_rd_en (rf_rd_en),
      .i_rf_rd_data (rf_rd_data), .i_rf_rd_vld (rf_rd_vld),
      .o_alu_fun (alu_fun), .o_alu_en (alu_en), .o_alu_clk_en (alu_clk_en),
      .i_alu_out (alu_out), .i_alu_out_vld (alu_out_vld),
      .o_rsp_data (rsp_data), .o_rsp_vld (rsp_vld), .i_rsp_ready (rsp_ready),
      .o_drop (drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_ev_t;
   typedef struct { int cyc; logic [AW-1:0] addr; } rd_ev_t;
   typedef struct { int cyc; logic [FW-1:0] fun; } alu_ev_t;

   wr_ev_t        wr_q[$];
   rd_ev_t        rd_q[$];
   alu_ev_t       alu_q[$];
   int            drop_q[$];
   logic [DW-1:0] rsp_q[$];

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // rsp_ready source: 0 forced low, 1 forced high, 2 random
   int ready_mode = 2;
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       rsp_ready = 1'b0;
         1:       rsp_ready = 1'b1;
         default: rsp_ready = ($urandom_range(0, 99) < 60);
      endcase
   end

   wr_ev_t        m_wr;
   rd_ev_t        m_rd;
   alu_ev_t       m_alu;
   int            m_drop;
   logic [DW-1:0] m_rsp;
   logic [DW-1:0] held_data;
   logic          held = 1'b0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (rf_wr_en) begin
            if (wr_q.size() == 0) check("unexpected_wr", 1, 0);
            else begin
               m_wr = wr_q.pop_front();
               check("wr_cycle", cyc, m_wr.cyc);
               check("wr_addr", rf_addr, m_wr.addr);
               check("wr_data", rf_wr_data, m_wr.data);
            end
         end
         if (rf_rd_en) begin
            if (rd_q.size() == 0) check("unexpected_rd", 1, 0);
            else begin
               m_rd = rd_q.pop_front();
               check("rd_cycle", cyc, m_rd.cyc);
               check("rd_addr", rf_addr, m_rd.addr);
            end
         end
         if (alu_en) begin
            if (alu_q.size() == 0) check("unexpected_alu", 1, 0);
            else begin
               m_alu = alu_q.pop_front();
               check("alu_cycle", cyc, m_alu.cyc);
               check("alu_fun", alu_fun, m_alu.fun);
            end
         end
         if (drop) begin
            if (drop_q.size() == 0) check("unexpected_drop", 1, 0);
            else begin
               m_drop = drop_q.pop_front();
               check("drop_cycle", cyc, m_drop);
            end
         end
         if (rsp_vld) begin
            if (held) check("rsp_stable", rsp_data, held_data);
            if (rsp_ready) begin
               held = 1'b0;
               if (rsp_q.size() == 0) check("unexpected_rsp", 1, 0);
               else begin
                  m_rsp = rsp_q.pop_front();
                  check("rsp_data", rsp_data, m_rsp);
               end
            end else begin
               held      = 1'b1;
               held_data = rsp_data;
            end
         end else begin
            held = 1'b0;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick();
   endtask

   task automatic send(input logic [7:0] b, input logic err, output int t);
      rx_data = b;
      rx_vld  = 1'b1;
      rx_err  = err;
      t       = cyc;
      tick();
      rx_vld  = 1'b0;
      rx_err  = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic drain();
      int n = 0;
      while (rsp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) begin
         check("rsp_drain_timeout", rsp_q.size(), 0);
         rsp_q.delete();
      end
   endtask

   task automatic frame_wr(input logic [7:0] abyte, input logic [7:0] d);
      int t;
      wr_ev_t e;
      send(8'hAA, 1'b0, t); gap();
      send(abyte, 1'b0, t); gap();
      send(d, 1'b0, t);
      e.cyc = t + 1; e.addr = abyte[AW-1:0]; e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic rd_part(input logic [7:0] abyte, input logic [7:0] d, input int lat, input bit stray);
      int t, ts;
      rd_ev_t e;
      send(8'hBB, 1'b0, t); gap();
      send(abyte, 1'b0, t);
      e.cyc = t + 1; e.addr = abyte[AW-1:0];
      rd_q.push_back(e);
      if (stray && lat >= 3 && lat < TO) begin
         wait_until(t + 2);
         send(8'($urandom), 1'($urandom), ts);
         drop_q.push_back(ts + 1);
      end
      if (lat >= TO) begin
         drop_q.push_back(t + 1 + TO);
         wait_until(t + 2 + TO);
      end else begin
         wait_until(t + 1 + lat);
         rf_rd_data = d;
         rf_rd_vld  = 1'b1;
         rsp_q.push_back(d);
         tick();
         rf_rd_vld  = 1'b0;
         rf_rd_data = 8'($urandom);
      end
   endtask

   task automatic alu_part(input bit ops, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] fbyte, input logic [15:0] res,
                           input int lat, input bit stray);
      int t, ts;
      wr_ev_t w;
      alu_ev_t e;
      if (ops) begin
         send(8'hCC, 1'b0, t); gap();
         send(a, 1'b0, t);
         w.cyc = t + 1; w.addr = 4'd0; w.data = a; wr_q.push_back(w);
         gap();
         send(b, 1'b0, t);
         w.cyc = t + 1; w.addr = 4'd1; w.data = b; wr_q.push_back(w);
         gap();
      end else begin
         send(8'hDD, 1'b0, t); gap();
      end
      send(fbyte, 1'b0, t);
      e.cyc = t + 1; e.fun = fbyte[FW-1:0];
      alu_q.push_back(e);
      check("clk_en_wait", alu_clk_en, 1);
      if (stray && lat >= 3 && lat < TO) begin
         wait_until(t + 2);
         send(8'($urandom), 1'($urandom), ts);
         drop_q.push_back(ts + 1);
      end
      if (lat >= TO) begin
         drop_q.push_back(t + 1 + TO);
         wait_until(t + 2 + TO);
         check("clk_en_after_timeout", alu_clk_en, 0);
      end else begin
         wait_until(t + 1 + lat);
         alu_out     = res;
         alu_out_vld = 1'b1;
         rsp_q.push_back(res[7:0]);
         rsp_q.push_back(res[15:8]);
         tick();
         alu_out_vld = 1'b0;
         alu_out     = 16'($urandom);
      end
   endtask

   task automatic err_partial(input int kind);
      int t;
      case (kind)
         0: begin send(8'hAA, 1'b0, t); gap(); end
         1: begin send(8'hAA, 1'b0, t); gap(); send(8'($urandom), 1'b0, t); gap(); end
         2: begin send(8'hBB, 1'b0, t); gap(); end
         3: begin send(8'hCC, 1'b0, t); gap(); end
         default: begin send(8'hDD, 1'b0, t); gap(); end
      endcase
      send(8'($urandom), 1'b1, t);
      drop_q.push_back(t + 1);
      check("clk_en_after_err", alu_clk_en, 0);
   endtask

   function automatic int rand_lat();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return TO + $urandom_range(0, 3);
      if (r == 1) return TO - 1;
      return $urandom_range(0, 8);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, n, kind, lat;
      logic [7:0] b;
      logic [29:0] outs;

      // reset state
      repeat (2) tick();
      outs = {rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_en,
              rsp_data, rsp_vld, drop};
      check("reset_outputs", 32'(outs), 0);
      reset_n = 1'b1;
      tick();

      // RF write AA,05,3C
      frame_wr(8'h05, 8'h3C);
      repeat (3) tick();
      check("wr_no_rsp", rsp_vld, 0);

      // RF read with transmitter stalled for 10 cycles
      ready_mode = 0;
      rd_part(8'h07, 8'h9E, 3, 1'b0);
      repeat (10) tick();
      check("rd_held_vld", rsp_vld, 1);
      check("rd_held_data", rsp_data, 8'h9E);
      ready_mode = 1;
      drain();
      tick();
      check("rd_vld_dropped", rsp_vld, 0);
      ready_mode = 2;

      // ALU with operands
      alu_part(1'b1, 8'h12, 8'h34, 8'h01, 16'h0246, 4, 1'b0);
      drain();
      check("clk_en_after_rsp", alu_clk_en, 0);

      // error abort, unknown command, then a normal write
      send(8'hAA, 1'b0, t);
      send(8'h05, 1'b0, t);
      send(8'h5A, 1'b1, t);
      drop_q.push_back(t + 1);
      send(8'h77, 1'b0, t);
      drop_q.push_back(t + 1);
      frame_wr(8'h01, 8'hFF);
      repeat (3) tick();

      // ALU timeout, then read whose data lands on the expiry cycle
      alu_part(1'b0, 8'h00, 8'h00, 8'h03, 16'h0000, TO, 1'b0);
      check("timeout_no_rsp", rsp_vld, 0);
      rd_part(8'h0C, 8'hC3, TO - 1, 1'b0);
      drain();

      // byte arriving with the final response handshake is dropped
      ready_mode = 0;
      rd_part(8'h03, 8'h5D, 1, 1'b0);
      n = 0;
      while (!rsp_vld && n < 20) begin tick(); n++; end
      check("rsp_vld_seen", rsp_vld, 1);
      ready_mode = 1;
      send(8'hAA, 1'b0, t);
      drop_q.push_back(t + 1);
      drain();
      tick();
      check("state_idle_after_hs_byte", rsp_vld, 0);
      ready_mode = 2;

      // reset in ALU_WAIT, then a normal read
      send(8'hDD, 1'b0, t);
      send(8'h05, 1'b0, t);
      begin
         alu_ev_t e;
         e.cyc = t + 1; e.fun = 4'h5;
         alu_q.push_back(e);
      end
      repeat (3) tick();
      check("clk_en_before_reset", alu_clk_en, 1);
      #2;
      reset_n = 1'b0;
      #1;
      outs = {rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_en,
              rsp_data, rsp_vld, drop};
      check("async_reset_outputs", 32'(outs), 0);
      tick();
      reset_n = 1'b1;
      tick();
      rd_part(8'h02, 8'h6B, 2, 1'b0);
      drain();

      // randomized frames
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 5);
         lat  = rand_lat();
         case (kind)
            0: frame_wr(8'($urandom), 8'($urandom));
            1: begin rd_part(8'($urandom), 8'($urandom), lat, 1'($urandom)); drain(); end
            2: begin
               alu_part(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), lat, 1'($urandom));
               drain();
               check("rand_clk_en_idle", alu_clk_en, 0);
            end
            3: begin
               alu_part(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom), lat, 1'($urandom));
               drain();
               check("rand_clk_en_idle", alu_clk_en, 0);
            end
            4: err_partial($urandom_range(0, 4));
            default: begin
               b = 8'($urandom);
               while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
               send(b, 1'b0, t);
               drop_q.push_back(t + 1);
            end
         endcase
         gap();
      end

      repeat (5) tick();
      check("leftover_expected", wr_q.size() + rd_q.size() + alu_q.size() + drop_q.size() + rsp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Downstream consumer of the UART receive path. It takes validated RX bytes (parallel data plus a one-cycle valid strobe) and parses multi-byte command frames. It then issues register-file writes and reads and ALU operations, and presents response bytes through a valid/ready handshake to the UART transmit path. This block is the receive/dispatch half of the system controller.

Parameters:
DATA_WIDTH, 8, width of RX bytes, RF data and response bytes
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width
WAIT_TIMEOUT, 255, max cycles spent in a wait state before abort

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
rx_data  input  DATA_WIDTH  received byte from UART receiver
rx_vld  input  1  one-cycle strobe, rx_data valid
rx_err  input  1  parity/stop/start error for the byte strobed this cycle
rf_addr  output  ADDR_WIDTH  register-file address
rf_wr_data  output  DATA_WIDTH  register-file write data
rf_wr_en  output  1  one-cycle write pulse
rf_rd_en  output  1  one-cycle read pulse
rf_rd_data  input  DATA_WIDTH  register-file read data
rf_rd_vld  input  1  read data valid strobe
alu_fun  output  FUN_WIDTH  ALU function code
alu_en  output  1  one-cycle ALU start pulse
alu_clk_en  output  1  ALU clock-gate enable, high during ALU commands
alu_out  input  2*DATA_WIDTH  ALU result
alu_out_vld  input  1  ALU result valid strobe
rsp_data  output  DATA_WIDTH  response byte to UART transmitter
rsp_vld  output  1  response valid; held until accepted
rsp_ready  input  1  transmitter can accept (driven by not-Busy)
drop  output  1  one-cycle pulse: byte discarded or wait timed out

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - All outputs 0, timeout counter 0, latched operands/result 0.
- Command codes:
  - 0xAA: RF write. Frame is cmd, addr, data.
  - 0xBB: RF read. Frame is cmd, addr.
  - 0xCC: ALU with operands. Frame is cmd, A, B, fun.
  - 0xDD: ALU without operands. Frame is cmd, fun.
- Byte acceptance:
  - A byte is consumed only in the cycle rx_vld=1.
  - A byte with rx_err=1 is discarded and pulses drop. It aborts any partially received frame (state returns to IDLE).
  - In IDLE, an unknown command byte pulses drop and state stays IDLE.
  - A byte arriving in a wait or response state is discarded and pulses drop; state is unchanged.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, RSP_LO, RSP_HI, RSP_RD.
- Transitions:
  - IDLE: 0xAA goes to WR_ADDR; 0xBB to RD_ADDR; 0xCC to OP_A; 0xDD to ALU_FUN.
  - WR_ADDR latches addr and goes to WR_DATA. WR_DATA writes, then goes to IDLE.
  - RD_ADDR issues the read and goes to RD_WAIT. On rf_rd_vld, latch rf_rd_data and go to RSP_RD.
  - OP_A writes A to rf_addr 0 and goes to OP_B. OP_B writes B to rf_addr 1 and goes to ALU_FUN.
  - ALU_FUN issues the ALU start and goes to ALU_WAIT. On alu_out_vld, latch alu_out and go to RSP_LO.
  - RSP_RD: when rsp_vld and rsp_ready are both 1, go to IDLE.
  - RSP_LO sends result[7:0]; on handshake go to RSP_HI. RSP_HI sends result[15:8]; on handshake go to IDLE.
- Timing (all outputs registered):
  - A frame's final byte strobed at cycle N gives the rf_wr_en, rf_rd_en or alu_en pulse at N+1, exactly one cycle wide.
  - rf_addr, rf_wr_data and alu_fun are valid in the same cycle as their pulse and hold until the next command.
- Response handshake:
  - rsp_vld rises the cycle after the result is latched.
  - rsp_data is stable while rsp_vld=1.
  - A transfer occurs in the cycle with rsp_vld and rsp_ready both 1. After the last byte, rsp_vld drops the next cycle.
- alu_clk_en:
  - Rises with entry to OP_A or ALU_FUN.
  - Falls on entry to RSP_LO, or on abort.
- Timeout:
  - In RD_WAIT and ALU_WAIT a counter increments every cycle.
  - Reaching WAIT_TIMEOUT returns state to IDLE, pulses drop and produces no response.
  - The counter clears on state entry.
- Simultaneous events:
  - rf_rd_vld or alu_out_vld in the same cycle as timeout expiry: the valid wins.
  - rx_vld in the same cycle as the final response handshake: the byte is dropped (state is still RSP).
- Reset asserted mid-frame or mid-response: immediate return to IDLE with all pulses and rsp_vld cleared.

Decomposition:
- Shared package: command code constants (CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP), state enum, RF operand addresses (OPA_ADDR=0, OPB_ADDR=1).
- One natural sub-module: uart_cmd_rsp_mux, which serialises 1- or 2-byte responses onto the valid/ready handshake.
- The FSM and timeout counter stay in the top.

Test Plan:
- RF write: bytes AA,05,3C → single rf_wr_en with rf_addr=5, rf_wr_data=0x3C one cycle after 3C; no rsp_vld.
- RF read: bytes BB,07, then rf_rd_data=0x9E with rf_rd_vld 3 cycles later; rsp_ready=0 for 10 cycles → rsp_vld held with rsp_data=0x9E; on release, exactly one transfer.
- ALU with operands: bytes CC,12,34,01 → writes 0x12@0 and 0x34@1, then alu_en with alu_fun=1 and alu_clk_en high; alu_out=0x0246 → responses 0x46 then 0x02, then IDLE.
- Errors: bytes AA,05 then a byte with rx_err=1 → drop pulse, no write; a following 0x77 in IDLE → drop pulse; a following AA,01,FF → normal write.
- Timeout: bytes DD,03 with no alu_out_vld → drop pulse after 255 cycles, alu_clk_en low, no response; rf_rd_vld arriving on the expiry cycle → response is produced.
- Reset mid-ALU_WAIT: reset low for 1 cycle → all outputs 0 asynchronously; the next frame BB,02 completes normally.
